// File: rtl/keypad_pkg.sv
// ----------------------------------------------------------------------------
// keypad_pkg
//   Shared definitions for the keypad / two-digit display slice:
//     - disp_state_t : display multiplex FSM states
//     - KEY_MAP      : 4x4 keypad map, indexed [row][col]
//     - is_onehot4   : exactly-one-bit-set test for a 4-bit line vector
//     - onehot4_idx  : bit position of a one-hot 4-bit vector
// ----------------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [1:0] {
        SHOW0  = 2'd0,
        BLANK0 = 2'd1,
        SHOW1  = 2'd2,
        BLANK1 = 2'd3
    } disp_state_t;

    // Physical keypad layout, row 0 at the top, column 0 at the left.
    localparam logic [3:0] KEY_MAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    // Clearing the lowest set bit leaves zero only for a single-bit value.
    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Only meaningful for one-hot input; otherwise returns the highest set bit.
    function automatic logic [1:0] onehot4_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (v[i]) begin
                idx = i[1:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_decode.sv
// ----------------------------------------------------------------------------
// keypad_decode
//   Purely combinational translation of a scanned row/column pair into the
//   hex code of the key at that position.
//
//   Ports:
//     rows  [3:0] in  : one-hot row being driven, bit i = row i
//     col   [3:0] in  : sensed column lines, bit j = column j
//     code  [3:0] out : hex code from KEY_MAP (only meaningful when valid)
//     valid       out : rows and col are each exactly one-hot
// ----------------------------------------------------------------------------
module keypad_decode
    import keypad_pkg::*;
(
    input  logic [3:0] rows,
    input  logic [3:0] col,
    output logic [3:0] code,
    output logic       valid
);

    logic [1:0] row_idx;
    logic [1:0] col_idx;

    always_comb begin
        row_idx = onehot4_idx(rows);
        col_idx = onehot4_idx(col);
        valid   = is_onehot4(rows) && is_onehot4(col);
        code    = KEY_MAP[row_idx][col_idx];
    end

endmodule

// File: rtl/keypad_display_ctrl.sv
// ----------------------------------------------------------------------------
// keypad_display_ctrl
//   Accepts debounced key strobes from a keypad scanner, keeps the two most
//   recent keys, and time-multiplexes them onto a two-digit display with an
//   all-off dead time between digit slots.
//
//   Parameters:
//     MUX_CYC   : clock cycles per digit-on slot (>= 2)
//     BLANK_CYC : clock cycles of all-off dead time between slots (>= 1)
//
//   Ports:
//     clk            in  : clock, rising edge
//     reset          in  : asynchronous, active-low reset
//     num_new        in  : single-cycle strobe, new debounced press
//     rows     [3:0] in  : one-hot scanner row
//     col      [3:0] in  : sensed column lines
//     disp_hex [3:0] out : hex code of the digit currently shown
//     anode_n  [1:0] out : active-low digit enables, bit0 = newest, bit1 = older
//     key_valid      out : one-cycle pulse, strobe accepted
//     key_err        out : one-cycle pulse, strobe rejected
// ----------------------------------------------------------------------------
module keypad_display_ctrl
    import keypad_pkg::*;
#(
    parameter int unsigned MUX_CYC   = 10000,
    parameter int unsigned BLANK_CYC = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       num_new,
    input  logic [3:0] rows,
    input  logic [3:0] col,
    output logic [3:0] disp_hex,
    output logic [1:0] anode_n,
    output logic       key_valid,
    output logic       key_err
);

    localparam int unsigned MAX_CYC    = (MUX_CYC > BLANK_CYC) ? MUX_CYC : BLANK_CYC;
    localparam int unsigned CW         = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] MUX_LOAD   = CW'(MUX_CYC - 1);
    localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYC - 1);

    // ------------------------------------------------------------------
    // Key capture: two-deep digit shift register
    // ------------------------------------------------------------------
    logic [3:0] dec_code;
    logic       dec_valid;

    logic [3:0] dig_new_q, dig_new_d;
    logic [3:0] dig_old_q, dig_old_d;
    logic       key_valid_q, key_valid_d;
    logic       key_err_q, key_err_d;

    keypad_decode u_decode (
        .rows  (rows),
        .col   (col),
        .code  (dec_code),
        .valid (dec_valid)
    );

    always_comb begin
        dig_new_d   = dig_new_q;
        dig_old_d   = dig_old_q;
        key_valid_d = 1'b0;
        key_err_d   = 1'b0;
        if (num_new) begin
            if (dec_valid) begin
                dig_old_d   = dig_new_q;
                dig_new_d   = dec_code;
                key_valid_d = 1'b1;
            end else begin
                key_err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dig_new_q   <= '0;
            dig_old_q   <= '0;
            key_valid_q <= 1'b0;
            key_err_q   <= 1'b0;
        end else begin
            dig_new_q   <= dig_new_d;
            dig_old_q   <= dig_old_d;
            key_valid_q <= key_valid_d;
            key_err_q   <= key_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Display multiplex FSM: state register
    // ------------------------------------------------------------------
    disp_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Reset parks the FSM in BLANK1 so the first digit slot follows a full
    // dead-time period after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BLANK1;
            cnt_q   <= BLANK_LOAD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Display multiplex FSM: next state
    //   The counter is loaded with (slot length - 1) on entry, so a state
    //   lasts exactly its slot length including the terminal zero cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == '0) begin
            unique case (state_q)
                SHOW0: begin
                    state_d = BLANK0;
                    cnt_d   = BLANK_LOAD;
                end
                BLANK0: begin
                    state_d = SHOW1;
                    cnt_d   = MUX_LOAD;
                end
                SHOW1: begin
                    state_d = BLANK1;
                    cnt_d   = BLANK_LOAD;
                end
                BLANK1: begin
                    state_d = SHOW0;
                    cnt_d   = MUX_LOAD;
                end
                default: begin
                    state_d = BLANK1;
                    cnt_d   = BLANK_LOAD;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Display multiplex FSM: outputs
    //   Outputs are computed from the upcoming state so the registered
    //   anode/digit change on the same edge as the state. The digit is
    //   latched only on SHOW entry, from the digit registers' current
    //   (pre-update) contents, so a key accepted on that same edge waits
    //   for the next slot.
    // ------------------------------------------------------------------
    logic [3:0] disp_hex_q, disp_hex_d;
    logic [1:0] anode_n_q, anode_n_d;

    always_comb begin
        anode_n_d  = 2'b11;
        disp_hex_d = disp_hex_q;
        unique case (state_d)
            SHOW0: begin
                anode_n_d = 2'b10;
                if (state_q != SHOW0) begin
                    disp_hex_d = dig_new_q;
                end
            end
            SHOW1: begin
                anode_n_d = 2'b01;
                if (state_q != SHOW1) begin
                    disp_hex_d = dig_old_q;
                end
            end
            default: begin
                anode_n_d = 2'b11;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disp_hex_q <= '0;
            anode_n_q  <= 2'b11;
        end else begin
            disp_hex_q <= disp_hex_d;
            anode_n_q  <= anode_n_d;
        end
    end

    assign disp_hex  = disp_hex_q;
    assign anode_n   = anode_n_q;
    assign key_valid = key_valid_q;
    assign key_err   = key_err_q;

endmodule

// File: tb/tb_keypad_display_ctrl.sv
// ----------------------------------------------------------------------------
// tb_keypad_display_ctrl
//   Directed self-checking bench for keypad_display_ctrl with MUX_CYC=8,
//   BLANK_CYC=2 (display period of 20 cycles). The bench tracks the slot
//   phase of every negedge sample and the two digits it expects the design
//   to hold, and checks anode_n, disp_hex, key_valid and key_err each cycle.
// ----------------------------------------------------------------------------
module tb_keypad_display_ctrl;

    localparam int unsigned MUX_CYC   = 8;
    localparam int unsigned BLANK_CYC = 2;
    localparam int          PERIOD    = 2 * (MUX_CYC + BLANK_CYC);
    localparam int          SHOW1_PH  = MUX_CYC + BLANK_CYC;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       num_new = 1'b0;
    logic [3:0] rows = 4'd0;
    logic [3:0] col = 4'd0;
    logic [3:0] disp_hex;
    logic [1:0] anode_n;
    logic       key_valid;
    logic       key_err;

    int         n_checks = 0;
    int         n_fail = 0;
    int         ph = 0;
    logic [3:0] m_new = 4'd0;
    logic [3:0] m_old = 4'd0;
    logic [3:0] exp_disp = 4'd0;

    keypad_display_ctrl #(
        .MUX_CYC   (MUX_CYC),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .num_new   (num_new),
        .rows      (rows),
        .col       (col),
        .disp_hex  (disp_hex),
        .anode_n   (anode_n),
        .key_valid (key_valid),
        .key_err   (key_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        n_checks++;
        assert (anode_n !== 2'b00) else begin
            n_fail++;
            $error("FAIL anode_both_on: observed %b required not 00", anode_n);
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (ph %0d): observed %0h expected %0h", tag, ph, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_anode(input int p);
        if (p < int'(MUX_CYC))      return 2'b10;
        else if (p < SHOW1_PH)      return 2'b11;
        else if (p < PERIOD - int'(BLANK_CYC)) return 2'b01;
        else                        return 2'b11;
    endfunction

    // One clock: inputs already driven are sampled on the coming posedge;
    // the result is checked on the following negedge.
    task automatic tick(input logic strobe, input logic s_valid, input logic [3:0] s_code);
        @(negedge clk);
        ph = (ph + 1) % PERIOD;
        if (ph == 0)             exp_disp = m_new;
        else if (ph == SHOW1_PH) exp_disp = m_old;
        if (strobe && s_valid) begin
            m_old = m_new;
            m_new = s_code;
        end
        chk("anode_n",   {6'd0, anode_n}, {6'd0, exp_anode(ph)});
        chk("disp_hex",  {4'd0, disp_hex}, {4'd0, exp_disp});
        chk("key_valid", {7'd0, key_valid}, {7'd0, strobe && s_valid});
        chk("key_err",   {7'd0, key_err}, {7'd0, strobe && !s_valid});
    endtask

    task automatic idle(input int n);
        num_new = 1'b0;
        repeat (n) tick(1'b0, 1'b0, 4'd0);
    endtask

    task automatic press(input logic [3:0] r, input logic [3:0] c,
                         input logic v, input logic [3:0] code);
        rows    = r;
        col     = c;
        num_new = 1'b1;
        tick(1'b1, v, code);
    endtask

    task automatic goto_ph(input int target);
        num_new = 1'b0;
        for (int i = 0; i < PERIOD && ph != target; i++) begin
            tick(1'b0, 1'b0, 4'd0);
        end
    endtask

    initial begin
        // Reset held, with a strobe present that must be ignored
        rows = 4'b0001;
        col = 4'b0001;
        num_new = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_anode_n",   {6'd0, anode_n}, 8'h03);
            chk("rst_disp_hex",  {4'd0, disp_hex}, 8'h00);
            chk("rst_key_valid", {7'd0, key_valid}, 8'h00);
            chk("rst_key_err",   {7'd0, key_err}, 8'h00);
        end
        num_new = 1'b0;

        // Release: BLANK1 lasts 2 cycles, then SHOW0; idle through two periods
        reset = 1'b1;
        ph = PERIOD - int'(BLANK_CYC);
        idle(40);

        // Two back-to-back valid keys mid-SHOW0: '2' then 'D'
        goto_ph(2);
        press(4'b0001, 4'b0010, 1'b1, 4'h2);
        press(4'b1000, 4'b1000, 1'b1, 4'hD);
        idle(30);

        // Rejected strobes: two columns, no row, two rows
        press(4'b0100, 4'b0110, 1'b0, 4'h0);
        idle(3);
        press(4'b0000, 4'b0001, 1'b0, 4'h0);
        press(4'b0011, 4'b0001, 1'b0, 4'h0);
        idle(20);

        // Key '9' sampled on the SHOW0 entry edge: slot shows the old 'D'
        goto_ph(PERIOD - 1);
        press(4'b0100, 4'b0100, 1'b1, 4'h9);
        idle(22);

        // Asynchronous reset in the middle of SHOW1
        goto_ph(SHOW1_PH + 3);
        chk("pre_rst_disp", {4'd0, disp_hex}, 8'h0D);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_anode_n",  {6'd0, anode_n}, 8'h03);
        chk("async_rst_disp_hex", {4'd0, disp_hex}, 8'h00);
        chk("async_rst_key_valid", {7'd0, key_valid}, 8'h00);
        @(negedge clk);
        chk("held_rst_anode_n",  {6'd0, anode_n}, 8'h03);
        chk("held_rst_disp_hex", {4'd0, disp_hex}, 8'h00);

        // After release both digits must show the cleared value
        m_new = 4'd0;
        m_old = 4'd0;
        exp_disp = 4'd0;
        reset = 1'b1;
        ph = PERIOD - int'(BLANK_CYC);
        idle(22);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_display_ctrl.md
KEYPAD_DISPLAY_CTRL -- requirements
Module: keypad_display_ctrl

Interface
REQ-001 The block SHALL have parameter MUX_CYC, default 10000: clock cycles per digit-on slot; legal range >= 2.
REQ-002 The block SHALL have parameter BLANK_CYC, default 100: clock cycles of all-off dead time between slots; legal range >= 1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port num_new, input, 1 bit: single-cycle strobe from the keypad scanner marking a new debounced press.
REQ-006 The block SHALL have port rows, input, 4 bits: one-hot row currently driven by the scanner; bit i = row i.
REQ-007 The block SHALL have port col, input, 4 bits: sensed column lines; bit j = column j.
REQ-008 The block SHALL have port disp_hex, output, 4 bits: hex code of the digit currently shown.
REQ-009 The block SHALL have port anode_n, output, 2 bits: active-low digit enables; bit 0 = right (newest), bit 1 = left (older).
REQ-010 The block SHALL have port key_valid, output, 1 bit: one-cycle pulse when a key is accepted.
REQ-011 The block SHALL have port key_err, output, 1 bit: one-cycle pulse when a strobe is rejected.

Function
REQ-012 When num_new=1, the block SHALL sample rows and col in the same cycle.
REQ-013 A strobe SHALL be accepted only if rows and col are each exactly one-hot.
REQ-014 Key map, [row][col0..3], SHALL be: r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = E,0,F,D.
REQ-015 On accept, at the next edge the block SHALL set dig_old <= dig_new and dig_new <= decoded code, and pulse key_valid for 1 cycle (registered, latency 1).
REQ-016 On reject (zero or multiple bits set in rows or col), the digits SHALL be unchanged and key_err SHALL pulse for 1 cycle (latency 1).
REQ-017 The display FSM SHALL have states SHOW0, BLANK0, SHOW1, BLANK1, cycling in that order.
REQ-018 The FSM SHALL remain MUX_CYC cycles in each SHOW state and BLANK_CYC cycles in each BLANK state.
REQ-019 A down-counter SHALL be loaded on state entry and advance the state at 0; its width SHALL be clog2(max(MUX_CYC, BLANK_CYC)+1).
REQ-020 In SHOW0: anode_n = 2'b10 and disp_hex = dig_new captured on SHOW0 entry.
REQ-021 In SHOW1: anode_n = 2'b01 and disp_hex = dig_old captured on SHOW1 entry.
REQ-022 In BLANK states: anode_n = 2'b11 and disp_hex SHALL hold its last value.
REQ-023 disp_hex and anode_n SHALL be registered outputs, so that no digit value changes mid-slot.
REQ-024 If a key accept and a SHOW entry fall on the same edge, the SHOW capture SHALL use the pre-update digit values; the new value appears from the next SHOW entry.
REQ-025 Back-to-back strobes on consecutive cycles SHALL each be processed, with no strobe dropped.
REQ-026 anode_n SHALL never have both bits low in any cycle.

Reset
REQ-027 While reset=0, the block SHALL hold dig_old=0, dig_new=0, disp_hex=0, anode_n=2'b11, key_valid=0, key_err=0, FSM=BLANK1, counter=BLANK_CYC-1.
REQ-028 Reset assertion mid-slot SHALL force all reset values asynchronously.
REQ-029 After release, the first SHOW0 SHALL begin after BLANK_CYC cycles.

Structure
REQ-030 Shared package keypad_pkg SHALL hold the disp_state_t enum (SHOW0, BLANK0, SHOW1, BLANK1) and the 4x4 key-map constant.
REQ-031 Decode SHALL be a combinational sub-module keypad_decode (rows, col -> code[3:0], valid), reused by later blocks.
REQ-032 The top module SHALL contain the digit shift register, the FSM with its counter, and the output registers.

Verification
REQ-033 The bench SHALL run with MUX_CYC=8 and BLANK_CYC=2.
REQ-034 Reset then idle 40 cycles -> first anode_n=2'b10 exactly 2 cycles after release, with slot lengths 8/2/8/2 and disp_hex=0 throughout.
REQ-035 Strobe rows=0001, col=0010, then rows=1000, col=1000 -> key_valid pulses twice; SHOW0 shows 4'hD and SHOW1 shows 4'h2.
REQ-036 Strobe rows=0100, col=0110 -> key_err pulses 1 cycle; digits unchanged; key_valid stays 0.
REQ-037 Strobe aligned to the SHOW0 entry edge -> that slot shows the old value; the next SHOW0 shows the new one.
REQ-038 Assert reset mid-SHOW1 -> anode_n=2'b11 and digits=0 before the next edge.
REQ-039 Continuous check: anode_n is never 2'b00.
